vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Scan-timing generator for the Pong display path. It divides the system clock down to a pixel rate and produces the horizontal/vertical scan counters, sync pulses, a visible-area flag and per-pixel/per-frame strobes. The ball-position, paddle and renderer stages consume its `CounterX`/`CounterY` and `frame_tick`, and the VGA pins are driven from its `hsync`/`vsync`. Default timing is 640x480 @ 60 Hz from a 50 MHz `clk`.

## Interface
Parameters:
- `PIX_DIV`, 2: `clk` cycles per pixel; legal range 1..16.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Derived values:
- H_TOTAL = sum of the four H_* parameters (800 by default).
- V_TOTAL = sum of the four V_* parameters (525 by default).
- Both totals must be ≤ 1024.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `CounterX` out 10: current pixel column, 0..H_TOTAL-1.
- `CounterY` out 10: current line, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `display_on` out 1: high while the current pixel is inside the visible area.
- `pix_tick` out 1: one-`clk` strobe on the first `clk` of each new pixel.
- `frame_tick` out 1: one-`clk` strobe on entry to vertical blanking.

## Operation
Pixel divider:
- `div_cnt` counts 0..PIX_DIV-1 and wraps.
- The internal advance enable `adv` is high when `div_cnt == PIX_DIV-1`.
- With PIX_DIV=1, `adv` is high every `clk`.

Advance (on each `adv`):
- If `CounterX == H_TOTAL-1`, `CounterX` goes to 0. Otherwise it increments by 1.
- On the `CounterX` wrap only: if `CounterY == V_TOTAL-1`, `CounterY` goes to 0. Otherwise it increments by 1.
- All arithmetic is 10-bit unsigned. Counters never hold values ≥ their total.

Decodes are computed from the next counter values and registered on the same edge, so every output describes the pixel currently shown on `CounterX`/`CounterY`:
- `hsync` = 0 when H_VISIBLE+H_FRONT ≤ X < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
- `vsync` = 0 when V_VISIBLE+V_FRONT ≤ Y < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default).
- `display_on` = (X < H_VISIBLE) && (Y < V_VISIBLE).
- `pix_tick` = 1 on the `clk` following each `adv` edge, 0 otherwise.
- `frame_tick` = 1 for exactly one `clk`, coinciding with the `pix_tick` of the advance into (0, V_VISIBLE). Downstream position logic updates once per frame on this strobe.

Reset (all outputs registered):
- `rst` sets `div_cnt` = 0, `CounterX` = H_TOTAL-1 (799), `CounterY` = V_TOTAL-1 (524).
- It also sets `hsync` = 1, `vsync` = 1, `display_on` = 0, `pix_tick` = 0, `frame_tick` = 0.
- The first advance after reset therefore wraps to (0,0), so every frame, including the first, begins at pixel (0,0).
- Assertion mid-frame overrides any pending advance and takes effect on the next edge.
- `rst` has priority over `adv` on the same edge.

## Timing
- Sequence after `rst` falls: on the clk edge where it is sampled low, `div_cnt` goes 0→1. With PIX_DIV=2, the next edge is an `adv`.
- First pixel: 2 clk edges after `rst` deasserts, outputs show (0,0) with `display_on` = 1 and `pix_tick` = 1.
- Each pixel holds for exactly PIX_DIV clks. `pix_tick` is high only on the first of those clks.
- Line period = H_TOTAL×PIX_DIV clks (1600 by default).
- Frame period = H_TOTAL×V_TOTAL×PIX_DIV clks (840000 by default).
- `hsync` width = H_SYNC×PIX_DIV clks (192).
- `vsync` width = V_SYNC lines. Its edges coincide with X=0 transitions.
- Latency from a counter value to its decodes is zero: both change on the same edge.

## Test plan
- Reset values: hold `rst` 5 clks. Required: X=799, Y=524, `hsync`=`vsync`=1, `display_on`=0, `pix_tick`=`frame_tick`=0.
- First pixel: release `rst`. Required: exactly 2 clks later, (0,0) with `display_on`=1 and `pix_tick`=1; 2 clks after that, (1,0).
- Horizontal timing: run one line. Required: `hsync` low for X=656..751 (192 clks); `display_on` falls at X=640; X wraps 799→0 with Y incrementing 0→1 on that same edge.
- Vertical timing: run one full frame. Required: `vsync` low for Y=490..491 only; `display_on`=0 for all Y ≥ 480; Y wraps 524→0.
- frame_tick: run two frames. Required: exactly one 1-clk `frame_tick` per frame, at (0,480), with consecutive ticks spaced 840000 clks apart.
- Mid-frame reset: assert `rst` at (300,200). Required: next edge gives X=799, Y=524 and reset output values; restart as in the first-pixel test.

Source files
------------

// File: rtl/vga_scan_if.sv
// vga_scan_if: scan counters, syncs and strobes from the timing generator to its consumers
interface vga_scan_if;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       pix_tick;
    logic       frame_tick;

    modport master (
        output CounterX, CounterY, hsync, vsync, display_on, pix_tick, frame_tick
    );

    modport slave (
        input CounterX, CounterY, hsync, vsync, display_on, pix_tick, frame_tick
    );
endinterface

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: pixel-rate divider plus VGA scan counters, syncs, visible flag and strobes
module vga_scan_gen #(
    parameter int PIX_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input logic clk,
    input logic rst,
    vga_scan_if.master scan
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] Y_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);

    logic [3:0] div_cnt;
    logic [9:0] x, y, x_nxt, y_nxt;
    logic       adv, x_wrap;
    logic [10:0] xw, yw;

    assign adv    = div_cnt == DIV_LAST;
    assign x_wrap = adv && x == X_LAST;
    assign x_nxt  = adv ? (x_wrap ? 10'd0 : x + 10'd1) : x;
    assign y_nxt  = x_wrap ? (y == Y_LAST ? 10'd0 : y + 10'd1) : y;
    // widened so region bounds equal to 1024 still compare correctly
    assign xw     = {1'b0, x_nxt};
    assign yw     = {1'b0, y_nxt};

    // counters and decodes update together so outputs always describe the shown pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt         <= 4'd0;
            x               <= X_LAST;
            y               <= Y_LAST;
            scan.hsync      <= 1'b1;
            scan.vsync      <= 1'b1;
            scan.display_on <= 1'b0;
            scan.pix_tick   <= 1'b0;
            scan.frame_tick <= 1'b0;
        end else begin
            div_cnt         <= adv ? 4'd0 : div_cnt + 4'd1;
            x               <= x_nxt;
            y               <= y_nxt;
            scan.hsync      <= !(xw >= HS_START && xw < HS_END);
            scan.vsync      <= !(yw >= VS_START && yw < VS_END);
            scan.display_on <= xw < X_VIS && yw < Y_VIS;
            scan.pix_tick   <= adv;
            scan.frame_tick <= adv && x_nxt == 10'd0 && yw == Y_VIS;
        end
    end

    assign scan.CounterX = x;
    assign scan.CounterY = y;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: random run/reset sequences checked every clk against a pixel-index model
module tb_vga_scan_gen;
    localparam int P  = 2;
    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int k = 0;
    int cyc = 0;
    int last_ft = -1;
    int ft_seen = 0;

    vga_scan_if sif();

    vga_scan_gen #(
        .PIX_DIV(P), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scan(sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d k=%0d got=%0d exp=%0d", tag, cyc, k, obs, exp);
        end
    endtask

    // k counts clk edges since reset was last sampled; pixels advanced = k/P
    task automatic step();
        int n, l, ex, ey, pt;
        @(posedge clk);
        #1;
        cyc++;
        k = rst ? 0 : k + 1;
        n = k / P;
        if (n == 0) begin
            ex = HT - 1;
            ey = VT - 1;
            pt = 0;
        end else begin
            l  = (n - 1) % (HT * VT);
            ex = l % HT;
            ey = l / HT;
            pt = (k % P == 0) ? 1 : 0;
        end
        chk("x", int'(sif.CounterX), ex);
        chk("y", int'(sif.CounterY), ey);
        chk("hsync", int'(sif.hsync), (n > 0 && ex >= HV + HF && ex < HV + HF + HS) ? 0 : 1);
        chk("vsync", int'(sif.vsync), (n > 0 && ey >= VV + VF && ey < VV + VF + VS) ? 0 : 1);
        chk("display_on", int'(sif.display_on), (n > 0 && ex < HV && ey < VV) ? 1 : 0);
        chk("pix_tick", int'(sif.pix_tick), pt);
        chk("frame_tick", int'(sif.frame_tick), (pt == 1 && ex == 0 && ey == VV) ? 1 : 0);
        if (rst) last_ft = -1;
        else if (sif.frame_tick) begin
            ft_seen++;
            if (last_ft >= 0) chk("ft_gap", cyc - last_ft, HT * VT * P);
            last_ft = cyc;
        end
    endtask

    initial begin
        repeat (5) step();
        rst = 1'b0;
        repeat (3 * HT * VT * P + 100) step();
        chk("ft_count", ft_seen, 3);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(1, 1500)) step();
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            rst = 1'b0;
        end
        repeat (HT * VT * P + 50) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
